bus_master_ctrl: RTL and testbench
==================================

Name: bus_master_ctrl

Overview:
Parametrised control path for a bus master on the shared multi-slave bus. It accepts a read or write command for one of NUM_SLAVES slaves and requests that slave's bus segment from the arbiter. It then sequences the address and data phases under a grant/ready handshake, and reports completion or a timeout or fault. The block sits between the master command source and the arbiter/slave bus, and drives the master datapath's output-enable and capture strobes.

Parameters:
NUM_SLAVES, 2, number of slaves and request/grant pairs (2..8)
SEL_W, 3, width of the slave index; must satisfy 2**SEL_W >= NUM_SLAVES
TIMEOUT, 15, maximum wait in cycles for a grant (REQ) or for slave ready (DATA); legal range 2..2**CNT_W-1
CNT_W, 4, width of the wait counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  command strobe; sampled only in IDLE
write  in  1  1 = write, 0 = read; captured with start
slave_sel  in  SEL_W  0-based target slave index; captured with start
grant  in  NUM_SLAVES  per-slave grant from the arbiter
slv_ready  in  1  selected slave accepts/returns data this cycle
busreq  out  NUM_SLAVES  one-hot bus request
rw  out  1  bus direction, 1 = write
addr_oe  out  1  drive address onto the bus
wdata_oe  out  1  drive write data onto the bus
rdata_le  out  1  capture read data
sel_out  out  SEL_W  latched slave index
busy  out  1  transaction in progress
done  out  1  one-cycle completion pulse
err  out  1  one-cycle error pulse
err_code  out  2  00 none, 01 bad select, 10 grant fault, 11 slave timeout

Behaviour:
- Reset state: state = IDLE, busreq = 0, rw = 1, addr_oe = 0, wdata_oe = 0, rdata_le = 0, sel_out = 0, busy = 0, done = 0, err = 0, err_code = 00, counter = 0.
- State machine: IDLE, REQ, ADDR, DATA, DONE, ERR.
- Output timing: all outputs are registered/Moore, except rdata_le = (state==DATA) & ~write_q & slv_ready, which is combinational.
- IDLE:
  - start=1 with slave_sel < NUM_SLAVES: latch write_q and sel_out, clear err_code, counter = 0, go to REQ.
  - start=1 with slave_sel >= NUM_SLAVES: err pulse next cycle, err_code = 01, stay in IDLE.
  - start=0: hold.
  - rw = 1 in IDLE.
- REQ:
  - busreq[sel_out] = 1, busy = 1.
  - grant[sel_out] = 1: go to ADDR.
  - Otherwise the counter increments. When counter == TIMEOUT-1 without grant, go to ERR with err_code = 10. busreq is therefore high for exactly TIMEOUT cycles.
  - Grant on the same cycle as the timeout: grant wins.
  - grant bits for other slaves are ignored.
- ADDR:
  - Lasts exactly one cycle.
  - busreq held, addr_oe = 1, rw = write_q; go to DATA with counter = 0.
- DATA:
  - busreq held, rw = write_q, wdata_oe = write_q.
  - slv_ready = 1: go to DONE.
  - Otherwise the counter increments; timeout at TIMEOUT-1 goes to ERR with err_code = 11.
  - slv_ready on the same cycle as the timeout: ready wins.
- Lost grant: grant[sel_out] = 0 in any cycle of ADDR or DATA goes to ERR with err_code = 10. In DATA, a lost grant takes priority over slv_ready.
- DONE: busreq = 0, done = 1 for one cycle, then IDLE.
- ERR: busreq = 0, err = 1 for one cycle, then IDLE. err_code holds until the next accepted start.
- Commands while busy: start is ignored in every state except IDLE; there is no queueing.
- Latency: with start sampled at edge t, busreq rises at t+1. With grant high at t+1 and ready at t+3, done is high in cycle t+4 and the block is back in IDLE at t+5. Minimum start-to-done is 4 cycles.
- Back-to-back commands: a new start is accepted in the IDLE cycle following done or err.
- Reset mid-transaction: all outputs return immediately (asynchronously) to their reset values and busreq drops.

Test Plan:
- Write to slave 1: start, write=1, sel=1; grant[1] at the first REQ cycle; slv_ready on the first DATA cycle -> busreq=2'b10 for 3 cycles, addr_oe 1 cycle, wdata_oe 1 cycle, done pulses 4 cycles after start, err_code=00.
- Read from slave 0 with 3 wait states: slv_ready asserted on the 4th DATA cycle -> rdata_le high only in that cycle, rw=0 during ADDR/DATA, done the next cycle.
- Grant timeout: TIMEOUT=15, grant never asserted -> busreq high 15 cycles, err pulse, err_code=10, busreq low in the ERR cycle.
- Lost grant: grant[0] drops during DATA with slv_ready=1 in the same cycle -> err, err_code=10, no done.
- Bad select: NUM_SLAVES=2, sel=3 -> err pulse next cycle, err_code=01, busreq never asserted; a start during a transaction is ignored.
- Async reset asserted mid-DATA -> all outputs at reset values before the next clock edge; a new command afterwards completes normally.

Source files
------------

// File: rtl/bus_master_ctrl_if.sv
// Command, arbiter and slave-bus signals of the bus master control path.
// The master modport is the controller's view; slave is the environment's view.
interface bus_master_ctrl_if #(
  parameter int unsigned NUM_SLAVES = 2,
  parameter int unsigned SEL_W      = 3
);
  logic                  start;
  logic                  write;
  logic [SEL_W-1:0]      slave_sel;
  logic [NUM_SLAVES-1:0] grant;
  logic                  slv_ready;
  logic [NUM_SLAVES-1:0] busreq;
  logic                  rw;
  logic                  addr_oe;
  logic                  wdata_oe;
  logic                  rdata_le;
  logic [SEL_W-1:0]      sel_out;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [1:0]            err_code;

  modport master (
    input  start, write, slave_sel, grant, slv_ready,
    output busreq, rw, addr_oe, wdata_oe, rdata_le, sel_out, busy, done, err, err_code
  );

  modport slave (
    output start, write, slave_sel, grant, slv_ready,
    input  busreq, rw, addr_oe, wdata_oe, rdata_le, sel_out, busy, done, err, err_code
  );
endinterface

// File: rtl/bus_master_ctrl.sv
// Bus master control path: requests a slave segment, runs address and data phases
// under grant/ready handshakes, and reports done, grant faults and slave timeouts.
module bus_master_ctrl #(
  parameter int unsigned NUM_SLAVES = 2,
  parameter int unsigned SEL_W      = 3,
  parameter int unsigned TIMEOUT    = 15,
  parameter int unsigned CNT_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  bus_master_ctrl_if.master bus_io
);

  typedef enum logic [2:0] {StIdle, StReq, StAddr, StData, StDone, StErr} state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic             write_q, write_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       err_code_q, err_code_d;
  logic             bad_sel_q, bad_sel_d;
  logic             sel_valid;
  logic             grant_sel;
  logic             bus_active;

  assign sel_valid = 32'(bus_io.slave_sel) < NUM_SLAVES;

  // Only the grant line of the latched slave matters; other bits are ignored.
  always_comb begin
    grant_sel = 1'b0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (32'(sel_q) == i) grant_sel = bus_io.grant[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      write_q    <= 1'b0;
      sel_q      <= '0;
      cnt_q      <= '0;
      err_code_q <= 2'b00;
      bad_sel_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      err_code_q <= err_code_d;
      bad_sel_q  <= bad_sel_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    err_code_d = err_code_q;
    bad_sel_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus_io.start) begin
          if (sel_valid) begin
            write_d    = bus_io.write;
            sel_d      = bus_io.slave_sel;
            err_code_d = 2'b00;
            cnt_d      = '0;
            state_d    = StReq;
          end else begin
            bad_sel_d  = 1'b1;
            err_code_d = 2'b01;
          end
        end
      end
      StReq: begin
        // A grant arriving on the last allowed cycle still wins over the timeout.
        if (grant_sel) begin
          cnt_d   = '0;
          state_d = StAddr;
        end else if (cnt_q == CntLast) begin
          err_code_d = 2'b10;
          state_d    = StErr;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StAddr: begin
        if (!grant_sel) begin
          err_code_d = 2'b10;
          state_d    = StErr;
        end else begin
          cnt_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        // Losing the grant beats both ready and the slave timeout.
        if (!grant_sel) begin
          err_code_d = 2'b10;
          state_d    = StErr;
        end else if (bus_io.slv_ready) begin
          state_d = StDone;
        end else if (cnt_q == CntLast) begin
          err_code_d = 2'b11;
          state_d    = StErr;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign bus_active = (state_q == StReq) || (state_q == StAddr) || (state_q == StData);

  always_comb begin
    bus_io.busreq = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (bus_active && (32'(sel_q) == i)) bus_io.busreq[i] = 1'b1;
    end
    bus_io.rw       = ((state_q == StAddr) || (state_q == StData)) ? write_q : 1'b1;
    bus_io.addr_oe  = (state_q == StAddr);
    bus_io.wdata_oe = (state_q == StData) && write_q;
    bus_io.rdata_le = (state_q == StData) && !write_q && bus_io.slv_ready;
    bus_io.sel_out  = sel_q;
    bus_io.busy     = (state_q != StIdle);
    bus_io.done     = (state_q == StDone);
    bus_io.err      = (state_q == StErr) || bad_sel_q;
    bus_io.err_code = err_code_q;
  end

endmodule

// File: tb/tb_bus_master_ctrl.sv
// Randomized bench for bus_master_ctrl; each transaction's timeline and outcome is
// predicted from the grant/ready/drop delays chosen for it.
module tb_bus_master_ctrl;

  localparam int unsigned NumSlaves = 2;
  localparam int unsigned SelW      = 3;
  localparam int unsigned Timeout   = 15;
  localparam int unsigned CntW      = 4;
  localparam int          Never     = 99;

  logic clk = 1'b0;
  logic rst;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bus_master_ctrl_if #(.NUM_SLAVES(NumSlaves), .SEL_W(SelW)) bus_if ();

  bus_master_ctrl #(
    .NUM_SLAVES(NumSlaves),
    .SEL_W     (SelW),
    .TIMEOUT   (Timeout),
    .CNT_W     (CntW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus_if)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busreq"},   32'(bus_if.busreq),   0);
    check({tag, "_rw"},       32'(bus_if.rw),       1);
    check({tag, "_addr_oe"},  32'(bus_if.addr_oe),  0);
    check({tag, "_wdata_oe"}, 32'(bus_if.wdata_oe), 0);
    check({tag, "_rdata_le"}, 32'(bus_if.rdata_le), 0);
    check({tag, "_sel_out"},  32'(bus_if.sel_out),  0);
    check({tag, "_busy"},     32'(bus_if.busy),     0);
    check({tag, "_done"},     32'(bus_if.done),     0);
    check({tag, "_err"},      32'(bus_if.err),      0);
    check({tag, "_err_code"}, 32'(bus_if.err_code), 0);
  endtask

  task automatic drive_idle();
    bus_if.start     = 1'b0;
    bus_if.write     = 1'b0;
    bus_if.slave_sel = '0;
    bus_if.grant     = '0;
    bus_if.slv_ready = 1'b0;
  endtask

  // g: REQ cycles before grant; r: DATA wait cycles before ready; d: DATA cycle of grant
  // loss (-1 = none). Called and returns at a falling edge with the DUT idle.
  task automatic run_txn(input bit wr, input int sel, input int g, input int r, input int d);
    int end_exp, rd_exp, n_data, rd_c_exp;
    logic [1:0] code_exp;
    bit ok_exp, fin;
    int end_c, breq_n, breq_bad, busy_n, addr_n, addr_c, addr_rw, wdata_n, rd_n, rd_c;
    int rw_bad, selo;
    logic done_s, err_s;
    logic [1:0] code_s;
    logic [7:0] gv;

    if (g >= int'(Timeout)) begin
      end_exp = Timeout; code_exp = 2'b10; ok_exp = 0;
    end else if (d >= 0 && d <= r && d < int'(Timeout)) begin
      end_exp = g + 3 + d; code_exp = 2'b10; ok_exp = 0;
    end else if (r >= int'(Timeout)) begin
      end_exp = g + 2 + Timeout; code_exp = 2'b11; ok_exp = 0;
    end else begin
      end_exp = g + 3 + r; code_exp = 2'b00; ok_exp = 1;
    end
    n_data   = (g < int'(Timeout)) ? end_exp - (g + 2) : 0;
    rd_c_exp = g + 2 + r;
    rd_exp   = (!wr && g < int'(Timeout) && rd_c_exp <= end_exp - 1) ? 1 : 0;

    fin = 0; end_c = -1; breq_n = 0; breq_bad = 0; busy_n = 0; addr_n = 0; addr_c = -1;
    addr_rw = -1; wdata_n = 0; rd_n = 0; rd_c = -1; rw_bad = 0; selo = -1;
    done_s = 0; err_s = 0; code_s = 0;

    bus_if.start     = 1'b1;
    bus_if.write     = wr;
    bus_if.slave_sel = SelW'(sel);
    bus_if.grant     = NumSlaves'($urandom);
    bus_if.slv_ready = 1'($urandom);
    @(negedge clk);
    for (int c = 0; c < 64 && !fin; c++) begin
      gv = 8'($urandom);
      gv[sel] = (c >= g) && !(d >= 0 && c >= g + 2 + d);
      bus_if.grant     = gv[NumSlaves-1:0];
      bus_if.slv_ready = (c == g + 2 + r) ? 1'b1 : ((c < g + 2) ? 1'($urandom) : 1'b0);
      bus_if.start     = 1'($urandom);
      bus_if.slave_sel = SelW'($urandom);
      bus_if.write     = 1'($urandom);
      #1;
      if (bus_if.busreq != 0) begin
        breq_n++;
        if (32'(bus_if.busreq) != (32'd1 << sel)) breq_bad++;
      end
      busy_n  += int'(bus_if.busy);
      wdata_n += int'(bus_if.wdata_oe);
      if (bus_if.addr_oe) begin addr_n++; addr_c = c; addr_rw = int'(bus_if.rw); end
      if (bus_if.rdata_le) begin rd_n++; rd_c = c; end
      if ((bus_if.addr_oe || bus_if.wdata_oe) && bus_if.rw != wr) rw_bad++;
      if (bus_if.done || bus_if.err) begin
        fin = 1; end_c = c; done_s = bus_if.done; err_s = bus_if.err;
        code_s = bus_if.err_code; selo = int'(bus_if.sel_out);
      end
      @(negedge clk);
    end

    check("txn_finished", 32'(fin), 1);
    check("end_cycle", end_c, end_exp);
    check("done", 32'(done_s), 32'(ok_exp));
    check("err", 32'(err_s), 32'(!ok_exp));
    check("err_code", 32'(code_s), 32'(code_exp));
    check("sel_out", selo, sel);
    check("busreq_cycles", breq_n, end_exp);
    check("busreq_onehot", breq_bad, 0);
    check("busy_cycles", busy_n, end_exp + 1);
    check("addr_oe_cycles", addr_n, (g < int'(Timeout)) ? 1 : 0);
    if (g < int'(Timeout)) begin
      check("addr_cycle", addr_c, g + 1);
      check("addr_rw", addr_rw, int'(wr));
    end
    check("wdata_oe_cycles", wdata_n, wr ? n_data : 0);
    check("rdata_le_cycles", rd_n, rd_exp);
    if (rd_exp == 1) check("rdata_le_cycle", rd_c, rd_c_exp);
    check("rw_direction", rw_bad, 0);

    drive_idle();
    #1;
    check("idle_busy", 32'(bus_if.busy), 0);
    check("idle_busreq", 32'(bus_if.busreq), 0);
    check("idle_pulses", 32'({bus_if.done, bus_if.err}), 0);
    check("idle_err_code_hold", 32'(bus_if.err_code), 32'(code_exp));
    @(negedge clk);
  endtask

  task automatic run_bad_sel(input int sel);
    bus_if.start     = 1'b1;
    bus_if.write     = 1'($urandom);
    bus_if.slave_sel = SelW'(sel);
    @(negedge clk);
    drive_idle();
    #1;
    check("badsel_err", 32'(bus_if.err), 1);
    check("badsel_code", 32'(bus_if.err_code), 1);
    check("badsel_busreq", 32'(bus_if.busreq), 0);
    check("badsel_busy", 32'(bus_if.busy), 0);
    @(negedge clk);
    #1;
    check("badsel_err_once", 32'(bus_if.err), 0);
    check("badsel_code_hold", 32'(bus_if.err_code), 1);
    @(negedge clk);
  endtask

  initial begin
    int g, r, d;
    rst = 1'b1;
    drive_idle();
    #1;
    check_reset_vals("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_txn(1'b1, 1, 0, 0, -1);        // write slave 1, no waits
    run_txn(1'b0, 0, 0, 3, -1);        // read slave 0, three wait states
    run_txn(1'b1, 0, Never, 0, -1);    // grant never arrives
    run_txn(1'b0, 0, 0, 1, 1);         // grant lost together with ready
    run_bad_sel(3);
    run_txn(1'b0, 1, Timeout - 1, Timeout - 1, -1);  // grant and ready on their last cycles
    run_txn(1'b1, 1, 1, Never, -1);    // slave never ready

    // Asynchronous reset in the middle of a read data phase.
    bus_if.start = 1'b1; bus_if.write = 1'b0; bus_if.slave_sel = SelW'(1);
    @(negedge clk);
    drive_idle();
    bus_if.grant = 2'b10;
    repeat (3) @(negedge clk);
    #2;
    check("pre_reset_busy", 32'(bus_if.busy), 1);
    check("pre_reset_rw", 32'(bus_if.rw), 0);
    check("pre_reset_sel_out", 32'(bus_if.sel_out), 1);
    rst = 1'b1;
    #1;
    check_reset_vals("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    @(negedge clk);
    run_txn(1'b1, 1, 0, 0, -1);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        run_bad_sel(int'($urandom_range(NumSlaves, (1 << SelW) - 1)));
      end else begin
        case ($urandom_range(0, 7))
          0:       g = Never;
          1:       g = Timeout - 1;
          default: g = $urandom_range(0, 4);
        endcase
        case ($urandom_range(0, 7))
          0:       r = Never;
          1:       r = Timeout - 1;
          default: r = $urandom_range(0, 4);
        endcase
        d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, (r < 5) ? r : 5)) : -1;
        run_txn(1'($urandom), int'($urandom_range(0, NumSlaves - 1)), g, r, d);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
